adc_sample_averager: RTL and testbench



---
 rtl/adc_pkg.sv | 18 +
 rtl/adc_sample_averager_if.sv | 32 +++
 rtl/frame_complete_detect.sv | 38 +++
 rtl/adc_sample_averager.sv | 121 ++++++++++++
 tb/tb_adc_sample_averager.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Types and constants shared by the SPI receive stage and the ADC averager.
// Frame layout: [16] transfer busy, [10] MCP3002 null bit, [9:0] conversion result.
package adc_pkg;

    localparam int SAMPLE_W = 10;
    localparam int FRAME_W  = 17;
    localparam int BUSY_BIT = 16;
    localparam int NULL_BIT = 10;

    typedef logic [FRAME_W-1:0]  spi_frame_t;
    typedef logic [SAMPLE_W-1:0] adc_sample_t;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } avg_state_t;

endpackage

// File: rtl/adc_sample_averager_if.sv
// Output side of the averager: averaged result with valid/ready handshake and status.
interface adc_sample_averager_if #(
    parameter int SAMPLE_W = 10,
    parameter int LOG2_N   = 3
) ();

    logic                o_valid;
    logic [SAMPLE_W-1:0] o_avg;
    logic [LOG2_N-1:0]   o_count;
    logic                o_overrun;
    logic                o_null_err;
    logic                _i_out_ready;

    modport master (
        output o_valid,
        output o_avg,
        output o_count,
        output o_overrun,
        output o_null_err,
        input  _i_out_ready
    );

    modport slave (
        input  o_valid,
        input  o_avg,
        input  o_count,
        input  o_overrun,
        input  o_null_err,
        output _i_out_ready
    );

endinterface

// File: rtl/frame_complete_detect.sv
// Flags the cycle in which an SPI frame finishes (busy falls) and splits out its fields.
// Arming on the first idle cycle ensures a frame already in flight at reset release is ignored.
module frame_complete_detect
    import adc_pkg::*;
#(
    parameter int SAMPLE_W = adc_pkg::SAMPLE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  spi_frame_t          frame,
    output logic                done,
    output logic                null_bit,
    output logic [SAMPLE_W-1:0] sample
);

    logic prev_busy;
    logic armed;
    logic [BUSY_BIT-SAMPLE_W-1:0] unused_hdr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_busy <= 1'b0;
            armed     <= 1'b0;
        end else begin
            prev_busy <= frame[BUSY_BIT];
            if (!frame[BUSY_BIT]) begin
                armed <= 1'b1;
            end
        end
    end

    // Completion is judged on the live frame so the result is consumed on the same edge.
    assign done       = prev_busy & ~frame[BUSY_BIT] & armed;
    assign null_bit   = frame[NULL_BIT];
    assign sample     = frame[SAMPLE_W-1:0];
    assign unused_hdr = frame[BUSY_BIT-1:SAMPLE_W];

endmodule

// File: rtl/adc_sample_averager.sv
// Averages 2^LOG2_N MCP3002 results and offers the mean on a valid/ready port.
// Accumulation never stalls; a batch closing while the old mean is still held is dropped.
module adc_sample_averager
    import adc_pkg::*;
#(
    parameter int LOG2_N   = 3,
    parameter int SAMPLE_W = adc_pkg::SAMPLE_W
) (
    input  logic                   _i_clk,
    input  logic                   _i_rst,
    input  spi_frame_t             _i_frame,
    adc_sample_averager_if.master  avg_bus
);

    localparam int ACC_W = SAMPLE_W + LOG2_N;

    logic                done;
    logic                null_bit;
    logic [SAMPLE_W-1:0] sample;

    avg_state_t          state;
    avg_state_t          state_nxt;
    logic                load_avg;
    logic                drop_avg;

    logic [ACC_W-1:0]    acc_p0;
    logic [LOG2_N-1:0]   count_p0;
    logic [ACC_W-1:0]    acc_sum;
    logic                good;
    logic                bad;
    logic                close;

    logic [SAMPLE_W-1:0] avg_p1;
    logic                overrun_p1;
    logic                null_err_p1;

    function automatic logic [SAMPLE_W-1:0] trunc_avg(input logic [ACC_W-1:0] acc);
        return acc[ACC_W-1:LOG2_N];
    endfunction

    frame_complete_detect #(
        .SAMPLE_W (SAMPLE_W)
    ) u_detect (
        .clk      (_i_clk),
        .rst_n    (_i_rst),
        .frame    (_i_frame),
        .done     (done),
        .null_bit (null_bit),
        .sample   (sample)
    );

    assign good    = done & ~null_bit;
    assign bad     = done & null_bit;
    assign close   = good & (&count_p0);
    assign acc_sum = acc_p0 + ACC_W'(sample);

    always_ff @(posedge _i_clk or negedge _i_rst) begin
        if (!_i_rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_avg  = 1'b0;
        drop_avg  = 1'b0;
        case (state)
            ACCUM: begin
                if (close) begin
                    state_nxt = HOLD;
                    load_avg  = 1'b1;
                end
            end
            HOLD: begin
                if (close) begin
                    load_avg = avg_bus._i_out_ready;
                    drop_avg = ~avg_bus._i_out_ready;
                end else if (avg_bus._i_out_ready) begin
                    state_nxt = ACCUM;
                end
            end
        endcase
    end

    // Stage p0 -> p1: accumulate, close batch, capture mean and sticky status
    always_ff @(posedge _i_clk or negedge _i_rst) begin
        if (!_i_rst) begin
            acc_p0      <= '0;
            count_p0    <= '0;
            avg_p1      <= '0;
            overrun_p1  <= 1'b0;
            null_err_p1 <= 1'b0;
        end else begin
            if (close) begin
                acc_p0   <= '0;
                count_p0 <= '0;
            end else if (good) begin
                acc_p0   <= acc_sum;
                count_p0 <= count_p0 + LOG2_N'(1);
            end
            if (load_avg) begin
                avg_p1 <= trunc_avg(acc_sum);
            end
            if (drop_avg) begin
                overrun_p1 <= 1'b1;
            end
            if (bad) begin
                null_err_p1 <= 1'b1;
            end
        end
    end

    assign avg_bus.o_valid    = (state == HOLD);
    assign avg_bus.o_avg      = avg_p1;
    assign avg_bus.o_count    = count_p0;
    assign avg_bus.o_overrun  = overrun_p1;
    assign avg_bus.o_null_err = null_err_p1;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Scoreboard bench for adc_sample_averager: expected means are queued by the stimulus
// and popped by a monitor on every valid/ready transfer.
module tb_adc_sample_averager;
    import adc_pkg::*;

    localparam int LOG2_N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    spi_frame_t frame = '0;

    int checks   = 0;
    int failures = 0;
    logic [SAMPLE_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    adc_sample_averager_if #(.SAMPLE_W(SAMPLE_W), .LOG2_N(LOG2_N)) bus ();

    adc_sample_averager #(
        .LOG2_N   (LOG2_N),
        .SAMPLE_W (SAMPLE_W)
    ) dut (
        ._i_clk   (clk),
        ._i_rst   (rst),
        ._i_frame (frame),
        .avg_bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One SPI frame: busy high for 4 cycles, then low; returns just after the completion edge.
    task automatic send(input logic [15:0] word, input bit ready_at_drop);
        @(posedge clk); #2;
        frame = {1'b1, word};
        repeat (4) @(posedge clk);
        #2;
        frame = {1'b0, word};
        if (ready_at_drop) bus._i_out_ready = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic batch(input logic [15:0] word);
        repeat (8) send(word, 1'b0);
    endtask

    task automatic drain(input string name);
        @(posedge clk); #2;
        check(name, bus.o_valid, 0);
    endtask

    initial begin : monitor
        logic [SAMPLE_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rst && bus.o_valid && bus._i_out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_avg: got 0x%0h expected no output", bus.o_avg);
                end else begin
                    e = exp_q.pop_front();
                    check("avg_out", bus.o_avg, e);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bus._i_out_ready = 1'b1;
        #3;
        check("rst_valid",    bus.o_valid,    0);
        check("rst_avg",      bus.o_avg,      0);
        check("rst_count",    bus.o_count,    0);
        check("rst_overrun",  bus.o_overrun,  0);
        check("rst_null_err", bus.o_null_err, 0);
        @(posedge clk); #2;
        rst = 1'b1;

        // Constant 0x2A5 batch
        repeat (7) send(16'h02A5, 1'b0);
        check("t1_count7", bus.o_count, 7);
        check("t1_valid_before", bus.o_valid, 0);
        exp_q.push_back(10'h2A5);
        send(16'h02A5, 1'b0);
        check("t1_valid", bus.o_valid, 1);
        check("t1_count0", bus.o_count, 0);
        drain("t1_valid_fall");

        // Ramp 0..7 -> 28>>3
        exp_q.push_back(10'd3);
        for (int i = 0; i < 8; i++) send(16'(i), 1'b0);
        check("t2_avg", bus.o_avg, 3);
        drain("t2_valid_fall");

        // Full scale, no wrap
        exp_q.push_back(10'h3FF);
        batch(16'h03FF);
        check("t3_avg", bus.o_avg, 10'h3FF);
        drain("t3_valid_fall");

        // Null frame as 3rd of 9; good results 1..8 -> 36>>3
        exp_q.push_back(10'd4);
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h06A5, 1'b0);
        check("t4_null_err", bus.o_null_err, 1);
        check("t4_count2", bus.o_count, 2);
        for (int i = 3; i <= 8; i++) send(16'(i), 1'b0);
        check("t4_avg", bus.o_avg, 4);
        drain("t4_valid_fall");

        // Ready rises on the same edge a new batch closes
        bus._i_out_ready = 1'b0;
        exp_q.push_back(10'h100);
        exp_q.push_back(10'h200);
        batch(16'h0100);
        check("t6_hold_avg", bus.o_avg, 10'h100);
        repeat (7) send(16'h0200, 1'b0);
        check("t6_valid_held", bus.o_valid, 1);
        send(16'h0200, 1'b1);
        check("t6_avg_new", bus.o_avg, 10'h200);
        check("t6_valid_stays", bus.o_valid, 1);
        check("t6_no_overrun", bus.o_overrun, 0);
        drain("t6_valid_fall");

        // Overrun: two batches with ready low
        bus._i_out_ready = 1'b0;
        exp_q.push_back(10'h100);
        batch(16'h0100);
        batch(16'h0200);
        check("t5_avg_kept", bus.o_avg, 10'h100);
        check("t5_overrun", bus.o_overrun, 1);
        check("t5_valid", bus.o_valid, 1);
        @(posedge clk); #2;
        bus._i_out_ready = 1'b1;
        drain("t5_valid_fall");

        // Asynchronous reset mid-batch with a frame in flight at release
        repeat (5) send(16'h0050, 1'b0);
        check("t7_count5", bus.o_count, 5);
        @(posedge clk); #2;
        frame = {1'b1, 16'h03FF};
        #1;
        rst = 1'b0;
        #1;
        check("t7_rst_valid",    bus.o_valid,    0);
        check("t7_rst_avg",      bus.o_avg,      0);
        check("t7_rst_count",    bus.o_count,    0);
        check("t7_rst_overrun",  bus.o_overrun,  0);
        check("t7_rst_null_err", bus.o_null_err, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        frame = {1'b0, 16'h03FF};
        repeat (2) @(posedge clk);
        #2;
        check("t7_inflight_ignored", bus.o_count, 0);
        exp_q.push_back(10'h040);
        repeat (7) send(16'h0040, 1'b0);
        check("t7_count7", bus.o_count, 7);
        check("t7_valid_before", bus.o_valid, 0);
        send(16'h0040, 1'b0);
        check("t7_valid", bus.o_valid, 1);
        check("t7_avg", bus.o_avg, 10'h040);
        drain("t7_valid_fall");

        repeat (3) @(posedge clk);
        #2;
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
